// File: rtl/fsk16_pkg.sv
// rtl/fsk16_pkg.sv - shared 16FSK constants: header code, frequency table, deframer state encoding
package fsk16_pkg;

    localparam logic [7:0] HEAD_CODE     = 8'hE2;
    localparam int         DATA_SYMS_DEF = 256;

    // Signed MHz offsets, index = 4 coded bits; identical to the transmit mapper table
    localparam logic [7:0] FSK_FREQ_TAB [16] = '{
        8'hF1, 8'hF3, 8'hF5, 8'hF7, 8'hF9, 8'hFB, 8'hFD, 8'hFF,
        8'h01, 8'h03, 8'h05, 8'h07, 8'h09, 8'h0B, 8'h0D, 8'h0F
    };

    typedef enum logic [3:0] {
        ST_HUNT = 4'b0001,
        ST_HEAD = 4'b0010,
        ST_DATA = 4'b0100,
        ST_DONE = 4'b1000
    } rx_state_t;

endpackage

// File: rtl/rx_deframer_if.sv
// rtl/rx_deframer_if.sv - symbol input and coded-dibit output bundle of the receive deframer
interface rx_deframer_if;

    logic [7:0]  sym_in;
    logic        sym_valid;
    logic [1:0]  code_out;
    logic        code_valid;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;
    logic        sym_ovf;
    logic        locked;
    logic [15:0] err_cnt;

    modport master (
        output sym_in, sym_valid,
        input  code_out, code_valid, frame_start, frame_done, frame_err,
        input  sym_ovf, locked, err_cnt
    );

    modport slave (
        input  sym_in, sym_valid,
        output code_out, code_valid, frame_start, frame_done, frame_err,
        output sym_ovf, locked, err_cnt
    );

endinterface

// File: rtl/fsk_demap.sv
// rtl/fsk_demap.sv - inverse 16FSK map: frequency code to 4-bit index, match low for unknown codes
module fsk_demap
    import fsk16_pkg::*;
(
    input  logic [7:0] sym_in,
    output logic [3:0] idx,
    output logic       match
);

    always_comb begin
        idx   = 4'h0;
        match = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (sym_in == FSK_FREQ_TAB[i]) begin
                idx   = 4'(i);
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_deframer.sv
// rtl/rx_deframer.sv - 16FSK subframe header hunt, demap and dibit emission to the Viterbi decoder
// Optional unmatched-code counter on err_cnt built when RX_ERRCNT_EN is defined.
module rx_deframer #(
    parameter int         HEAD_LEN  = 8,
    parameter int         DATA_SYMS = fsk16_pkg::DATA_SYMS_DEF,
    parameter int         TIMEOUT   = 4095,
    parameter logic [7:0] HEAD_CODE = fsk16_pkg::HEAD_CODE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         En,
    rx_deframer_if.slave bus
);

    import fsk16_pkg::*;

    localparam int HCW = $clog2(HEAD_LEN + 1);
    localparam int SCW = $clog2(DATA_SYMS);
    localparam int ICW = $clog2(TIMEOUT + 1);

    rx_state_t      state, state_nxt;
    logic [HCW-1:0] head_cnt, head_cnt_nxt;
    logic [SCW-1:0] sym_cnt, sym_cnt_nxt, cur_sym;
    logic [ICW-1:0] idle_cnt, idle_cnt_nxt;
    logic           pend, pend_nxt, pend_last, pend_last_nxt;
    logic [1:0]     pend_bits, pend_bits_nxt;
    logic [1:0]     code_q, code_nxt;
    logic           code_valid_q, code_valid_nxt;
    logic           start_q, start_nxt, done_q, done_nxt, err_q, err_nxt, ovf_q, ovf_nxt;
    logic           take, is_head, match;
    logic [3:0]     idx;

    fsk_demap u_demap (
        .sym_in (bus.sym_in),
        .idx    (idx),
        .match  (match)
    );

    assign is_head = (bus.sym_in == HEAD_CODE);
    // The symbol that ends HEAD is data symbol 0 even though sym_cnt is stale there
    assign cur_sym = (state == ST_DATA) ? sym_cnt : '0;

    always_comb begin
        state_nxt      = state;
        head_cnt_nxt   = head_cnt;
        sym_cnt_nxt    = sym_cnt;
        idle_cnt_nxt   = idle_cnt;
        pend_nxt       = 1'b0;
        pend_last_nxt  = pend_last;
        pend_bits_nxt  = pend_bits;
        code_nxt       = 2'b00;
        code_valid_nxt = 1'b0;
        start_nxt      = 1'b0;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        ovf_nxt        = ovf_q;
        take           = 1'b0;
        if (!En) begin
            state_nxt     = ST_HUNT;
            head_cnt_nxt  = '0;
            sym_cnt_nxt   = '0;
            idle_cnt_nxt  = '0;
            pend_last_nxt = 1'b0;
            pend_bits_nxt = 2'b00;
            ovf_nxt       = 1'b0;
        end else begin
            case (state)
                ST_HUNT, ST_DONE: begin
                    // DONE also hunts so a header right after the last symbol is not lost
                    done_nxt  = (state == ST_DONE);
                    state_nxt = ST_HUNT;
                    if (bus.sym_valid && is_head) begin
                        head_cnt_nxt = HCW'(1);
                        state_nxt    = ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (bus.sym_valid) begin
                        if (is_head) begin
                            if (head_cnt != HCW'(HEAD_LEN))
                                head_cnt_nxt = head_cnt + HCW'(1);
                        end else if (head_cnt >= HCW'(HEAD_LEN)) begin
                            take      = 1'b1;
                            start_nxt = 1'b1;
                            state_nxt = ST_DATA;
                        end else begin
                            head_cnt_nxt = '0;
                            state_nxt    = ST_HUNT;
                        end
                    end
                end
                ST_DATA: begin
                    if (pend) begin
                        code_nxt       = pend_bits;
                        code_valid_nxt = 1'b1;
                        if (pend_last)
                            state_nxt = ST_DONE;
                    end
                    if (bus.sym_valid) begin
                        idle_cnt_nxt = '0;
                        if (pend)
                            ovf_nxt = 1'b1;
                        else
                            take = 1'b1;
                    end else if (idle_cnt == ICW'(TIMEOUT - 1)) begin
                        err_nxt        = 1'b1;
                        code_nxt       = 2'b00;
                        code_valid_nxt = 1'b0;
                        state_nxt      = ST_HUNT;
                    end else begin
                        idle_cnt_nxt = idle_cnt + ICW'(1);
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
            if (take) begin
                code_nxt       = idx[3:2];
                code_valid_nxt = 1'b1;
                pend_nxt       = 1'b1;
                pend_bits_nxt  = idx[1:0];
                pend_last_nxt  = (cur_sym == SCW'(DATA_SYMS - 1));
                sym_cnt_nxt    = pend_last_nxt ? '0 : cur_sym + SCW'(1);
                idle_cnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_HUNT;
            head_cnt     <= '0;
            sym_cnt      <= '0;
            idle_cnt     <= '0;
            pend         <= 1'b0;
            pend_last    <= 1'b0;
            pend_bits    <= 2'b00;
            code_q       <= 2'b00;
            code_valid_q <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            head_cnt     <= head_cnt_nxt;
            sym_cnt      <= sym_cnt_nxt;
            idle_cnt     <= idle_cnt_nxt;
            pend         <= pend_nxt;
            pend_last    <= pend_last_nxt;
            pend_bits    <= pend_bits_nxt;
            code_q       <= code_nxt;
            code_valid_q <= code_valid_nxt;
            start_q      <= start_nxt;
            done_q       <= done_nxt;
            err_q        <= err_nxt;
            ovf_q        <= ovf_nxt;
        end
    end

`ifdef RX_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (!En) begin
            err_cnt_q <= '0;
        end else if (take) begin
            if (start_nxt)
                err_cnt_q <= match ? 16'h0 : 16'h1;
            else if (!match && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'h1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 16'h0;
`endif

    assign bus.code_out    = code_q;
    assign bus.code_valid  = code_valid_q;
    assign bus.frame_start = start_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_err   = err_q;
    assign bus.sym_ovf     = ovf_q;
    assign bus.locked      = (state == ST_DATA);

endmodule

// File: tb/tb_rx_deframer.sv
// tb/tb_rx_deframer.sv - directed self-checking bench for rx_deframer
module tb_rx_deframer;

    localparam logic [7:0] HC = 8'hE2;
    localparam logic [7:0] TAB [16] = '{
        8'hF1, 8'hF3, 8'hF5, 8'hF7, 8'hF9, 8'hFB, 8'hFD, 8'hFF,
        8'h01, 8'h03, 8'h05, 8'h07, 8'h09, 8'h0B, 8'h0D, 8'h0F
    };
`ifdef RX_ERRCNT_EN
    localparam int ERR_EXP = 4;
`else
    localparam int ERR_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    int   cyc = 0;

    int total = 0, bad = 0;
    int fs_cnt, fd_cnt, fe_cnt, fd_cyc, fe_cyc, first_dv, last_dv, sv_cyc;
    logic [15:0] fd_err;
    logic [1:0]  got [$];
    logic [1:0]  exp_q [$];

    rx_deframer_if bus ();

    rx_deframer dut (
        .clk (clk),
        .rst (rst),
        .En  (en),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.code_valid) begin
            got.push_back(bus.code_out);
            last_dv = cyc;
            if (first_dv < 0) first_dv = cyc;
        end
        if (bus.frame_start) fs_cnt++;
        if (bus.frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            fd_err = bus.err_cnt;
        end
        if (bus.frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic clear();
        got.delete();
        exp_q.delete();
        fs_cnt = 0; fd_cnt = 0; fe_cnt = 0; first_dv = -1;
    endtask

    task automatic send(input logic [7:0] c, input int gap);
        bus.sym_in    = c;
        bus.sym_valid = 1'b1;
        sv_cyc = cyc;
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        repeat (gap - 1) begin @(posedge clk); #1; end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic en_pulse();
        en = 1'b0;
        wait_clk(1);
        en = 1'b1;
    endtask

    task automatic push_nib(input logic [3:0] n);
        exp_q.push_back(n[3:2]);
        exp_q.push_back(n[1:0]);
    endtask

    task automatic chk_stream(input string tag);
        int nbad = 0;
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int k = 0; k < got.size() && k < exp_q.size(); k++)
            if (got[k] !== exp_q[k]) nbad++;
        chk({tag, "_data"}, nbad, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.sym_in = 8'h00;
        bus.sym_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_code_valid", bus.code_valid, 0);
        chk("rst_code_out", bus.code_out, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_flags", {bus.frame_start, bus.frame_done, bus.frame_err, bus.sym_ovf}, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(2);

        // full frame, 40-clock spacing
        clear();
        repeat (8) send(HC, 4);
        send(TAB[0], 40);
        push_nib(4'h0);
        chk("s1_latency", first_dv - sv_cyc, 1);
        chk("s1_locked", bus.locked, 1);
        for (int i = 1; i < 256; i++) begin
            send(TAB[i % 16], 40);
            push_nib(4'(i % 16));
        end
        chk("s1_frame_start", fs_cnt, 1);
        chk_stream("s1_stream");
        chk("s1_frame_done", fd_cnt, 1);
        chk("s1_done_delay", fd_cyc - last_dv, 1);
        chk("s1_unlocked", bus.locked, 0);
        chk("s1_frame_err", fe_cnt, 0);

        // short header must not lock
        clear();
        repeat (7) send(HC, 4);
        send(TAB[5], 4);
        chk("s2_frame_start", fs_cnt, 0);
        chk("s2_code_valid", got.size(), 0);
        chk("s2_locked", bus.locked, 0);

        // long header locks, then En low drops lock without frame_err
        clear();
        repeat (12) send(HC, 3);
        send(TAB[10], 3);
        chk("s3_latency", first_dv - sv_cyc, 1);
        send(TAB[6], 3);
        push_nib(4'hA);
        push_nib(4'h6);
        chk("s3_frame_start", fs_cnt, 1);
        chk_stream("s3_stream");
        chk("s3_locked", bus.locked, 1);
        en_pulse();
        chk("s3_en_unlock", bus.locked, 0);
        chk("s3_en_no_err", fe_cnt, 0);

        // timeout abort and clean relock
        clear();
        repeat (8) send(HC, 3);
        for (int i = 0; i < 100; i++) begin
            send(TAB[i % 16], 3);
            push_nib(4'(i % 16));
        end
        for (int i = 0; i < 5000 && fe_cnt == 0; i++) wait_clk(1);
        wait_clk(1);
        chk("s4_frame_err", fe_cnt, 1);
        chk("s4_tmo_dist", fe_cyc - (sv_cyc + 1), 4095);
        chk("s4_no_done", fd_cnt, 0);
        chk("s4_unlocked", bus.locked, 0);
        chk_stream("s4_stream");
        clear();
        repeat (8) send(HC, 3);
        send(TAB[1], 3);
        send(TAB[2], 3);
        chk("s4_relock_start", fs_cnt, 1);
        chk("s4_relock_dibits", got.size(), 4);
        chk("s4_relock_locked", bus.locked, 1);
        en_pulse();

        // spacing violation: second of two back-to-back symbols dropped
        clear();
        repeat (8) send(HC, 3);
        send(TAB[3], 1);
        push_nib(4'h3);
        send(TAB[7], 3);
        chk("s5_ovf_set", bus.sym_ovf, 1);
        for (int i = 0; i < 255; i++) begin
            send(TAB[i % 16], 3);
            push_nib(4'(i % 16));
            if (i == 253) begin
                wait_clk(3);
                chk("s5_not_done_early", fd_cnt, 0);
            end
        end
        wait_clk(3);
        chk("s5_done", fd_cnt, 1);
        chk_stream("s5_stream");
        chk("s5_ovf_sticky", bus.sym_ovf, 1);
        en_pulse();
        chk("s5_ovf_cleared", bus.sym_ovf, 0);

        // unmatched codes including a header code inside DATA
        clear();
        repeat (8) send(HC, 3);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            logic [3:0] n;
            c = TAB[i % 16];
            n = 4'(i % 16);
            case (i)
                1: begin c = 8'h55; n = 4'h0; end
                3: begin c = 8'h80; n = 4'h0; end
                4: begin c = HC;    n = 4'h0; end
                5: begin c = 8'h7F; n = 4'h0; end
                default: ;
            endcase
            send(c, 3);
            push_nib(n);
        end
        wait_clk(4);
        chk("s6_done", fd_cnt, 1);
        chk("s6_err_at_done", fd_err, ERR_EXP);
        chk("s6_err_hold", bus.err_cnt, ERR_EXP);
        chk_stream("s6_stream");
        chk("s6_start_once", fs_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
